// File: rtl/delta_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : delta_pkg                                                        |
// | Shared widths, uio pin indices and the signed add/saturate helper.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package delta_pkg;

    localparam int DATA_W = 8;

    localparam int IN_VALID_B   = 0;
    localparam int OUT_READY_B  = 1;
    localparam int LOAD_B       = 2;
    localparam int SAT_EN_B     = 3;
    localparam int IN_READY_B   = 4;
    localparam int OUT_VALID_B  = 5;
    localparam int OVF_STICKY_B = 6;
    localparam int OVF_PULSE_B  = 7;

    localparam logic [DATA_W-1:0] UIO_OE_MASK = 8'hF0;
    localparam logic [DATA_W-1:0] SAT_MAX     = 8'h7F;
    localparam logic [DATA_W-1:0] SAT_MIN     = 8'h80;

    // Returns {ovf, result}; overflow is reported whether or not saturation is on.
    function automatic logic [DATA_W:0] sat_add8(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] delta,
        input logic              sat
    );
        logic [DATA_W:0]   w_sum;
        logic              w_ovf;
        logic [DATA_W-1:0] w_res;
        w_sum = {acc[DATA_W-1], acc} + {delta[DATA_W-1], delta};
        w_ovf = w_sum[DATA_W] ^ w_sum[DATA_W-1];
        if (sat && w_ovf)
            w_res = w_sum[DATA_W] ? SAT_MIN : SAT_MAX;
        else
            w_res = w_sum[DATA_W-1:0];
        return {w_ovf, w_res};
    endfunction

endpackage
`default_nettype wire

// File: rtl/delta_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : delta_fifo                                                       |
// | Small synchronous FIFO with extra-MSB wrap pointers.                       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module delta_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Same slot index but different lap bit means the writer is one lap ahead.
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_head  = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/tt_um_delta_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tt_um_delta_decoder                                              |
// | Accumulates signed deltas into absolute samples, FIFO-buffered output.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tt_um_delta_decoder
    import delta_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [DATA_W-1:0] RST_SEED = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] ui_in,
    input  logic [DATA_W-1:0] uio_in,
    output logic [DATA_W-1:0] uo_out,
    output logic [DATA_W-1:0] uio_out,
    output logic [DATA_W-1:0] uio_oe
);

    logic [DATA_W-1:0] r_acc;
    logic              r_ovf_sticky;
    logic              r_ovf_pulse;

    logic              w_in_valid;
    logic              w_out_ready;
    logic              w_load;
    logic              w_sat_en;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_next_acc;
    logic              w_ovf;
    logic              w_unused;

    assign w_in_valid  = uio_in[IN_VALID_B];
    assign w_out_ready = uio_in[OUT_READY_B];
    assign w_load      = uio_in[LOAD_B];
    assign w_sat_en    = uio_in[SAT_EN_B];
    assign w_unused    = ^uio_in[DATA_W-1:4];

    // rst_n gating keeps uio_out all-zero while reset is held, even with ena high.
    assign w_in_ready  = ena & rst_n & ~w_full;
    assign w_out_valid = ena & ~w_empty;
    assign w_accept    = w_in_valid & w_in_ready;
    assign w_pop       = w_out_valid & w_out_ready;

    assign w_sum      = sat_add8(r_acc, ui_in, w_sat_en);
    assign w_next_acc = w_load ? ui_in : w_sum[DATA_W-1:0];
    assign w_ovf      = ~w_load & w_sum[DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= RST_SEED;
            r_ovf_sticky <= 1'b0;
            r_ovf_pulse  <= 1'b0;
        end else begin
            r_ovf_pulse <= w_accept & w_ovf;
            if (w_accept) begin
                r_acc <= w_next_acc;
                if (w_load) r_ovf_sticky <= 1'b0;
                else        r_ovf_sticky <= r_ovf_sticky | w_ovf;
            end
        end
    end

    delta_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_data  (w_next_acc),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign uo_out = w_empty ? '0 : w_head;
    assign uio_oe = UIO_OE_MASK;

    always_comb begin
        uio_out               = '0;
        uio_out[IN_READY_B]   = w_in_ready;
        uio_out[OUT_VALID_B]  = w_out_valid;
        uio_out[OVF_STICKY_B] = r_ovf_sticky;
        uio_out[OVF_PULSE_B]  = r_ovf_pulse;
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_delta_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tt_um_delta_decoder                                           |
// | Directed vector table, multi-cycle sequences and a scoreboarded soak.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_tt_um_delta_decoder;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic       in_valid, out_ready, load, sat;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    assign uio_in = {4'b0000, sat, load, out_ready, in_valid};

    always #5 clk = ~clk;

    tt_um_delta_decoder #(.DEPTH(DEPTH), .RST_SEED(8'h00)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        logic [7:0] delta;
        logic       ld;
        logic       sat_en;
        logic [7:0] exp_out;
        logic       exp_sticky;
        logic       exp_pulse;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] d,
                                           input logic s_en);
        int         s;
        logic       o;
        logic [7:0] r;
        s = int'($signed(a)) + int'($signed(d));
        o = (s > 127) || (s < -128);
        if (o && s_en) r = (s > 127) ? 8'h7F : 8'h80;
        else           r = 8'(s);
        return {o, r};
    endfunction

    task automatic drive(input logic v, input logic r, input logic l, input logic s,
                         input logic [7:0] d);
        @(negedge clk);
        in_valid = v; out_ready = r; load = l; sat = s; ui_in = d;
    endtask

    logic [7:0] m_acc;
    logic       m_sticky;
    logic       m_pulse;
    logic [7:0] q [$];

    initial begin
        vecs[0]  = '{8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0};
        vecs[1]  = '{8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[2]  = '{8'hFE, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0};
        vecs[3]  = '{8'h7E, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0};
        vecs[4]  = '{8'h05, 1'b0, 1'b0, 8'h83, 1'b1, 1'b1};
        vecs[5]  = '{8'h7E, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0};
        vecs[6]  = '{8'h05, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[7]  = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[8]  = '{8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1};
        vecs[9]  = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[10] = '{8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[11] = '{8'h00, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0};
        vecs[12] = '{8'h10, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};

        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00;
        in_valid = 1'b0; out_ready = 1'b0; load = 1'b0; sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle in_ready", {7'b0, uio_out[4]}, 8'h01);

        // Streaming table: out_ready held high so each sample is popped as the next lands.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 1'b1, vecs[i].ld, vecs[i].sat_en, vecs[i].delta);
            @(posedge clk); #1;
            check($sformatf("vec%0d uo_out", i), uo_out, vecs[i].exp_out);
            check($sformatf("vec%0d out_valid", i), {7'b0, uio_out[5]}, 8'h01);
            check($sformatf("vec%0d sticky", i), {7'b0, uio_out[6]}, {7'b0, vecs[i].exp_sticky});
            check($sformatf("vec%0d pulse", i), {7'b0, uio_out[7]}, {7'b0, vecs[i].exp_pulse});
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("drain uo_out", uo_out, 8'h00);
        check("drain out_valid", {7'b0, uio_out[5]}, 8'h00);

        // Back-pressure: fill to DEPTH, confirm stall, then release in order.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        @(posedge clk); #1;
        check("bp1 uo_out", uo_out, 8'h01);
        @(posedge clk); #1;
        check("bp2 in_ready", {7'b0, uio_out[4]}, 8'h00);
        check("bp2 uo_out", uo_out, 8'h01);
        @(posedge clk); #1;
        check("bp3 hold", uo_out, 8'h01);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
        #1;
        check("bp full in_ready", {7'b0, uio_out[4]}, 8'h00);
        @(posedge clk); #1;
        check("bp4 uo_out", uo_out, 8'h02);
        check("bp4 in_ready", {7'b0, uio_out[4]}, 8'h01);
        @(posedge clk); #1;
        check("bp5 uo_out", uo_out, 8'h03);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("bp6 empty", uo_out, 8'h00);

        // Asynchronous reset mid-stream with a full FIFO.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        repeat (2) @(posedge clk);
        #1;
        check("pre-rst uo_out", uo_out, 8'h04);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst uo_out", uo_out, 8'h00);
        check("async rst uio_out", uio_out, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
        @(posedge clk); #1;
        check("post-rst uo_out", uo_out, 8'h01);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("post-rst drain", uo_out, 8'h00);

        // Scoreboarded random soak.
        m_acc = 8'h01; m_sticky = 1'b0; m_pulse = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            logic       ex_ir, ex_ov, acc_ev, pop_ev;
            logic [8:0] r;
            @(negedge clk);
            ena       = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            load      = ($urandom_range(0, 9) == 0);
            sat       = $urandom_range(0, 1) == 1;
            ui_in     = 8'($urandom);
            #1;
            ex_ir = ena && (q.size() < DEPTH);
            ex_ov = ena && (q.size() > 0);
            check("rnd in_ready", {7'b0, uio_out[4]}, {7'b0, ex_ir});
            check("rnd out_valid", {7'b0, uio_out[5]}, {7'b0, ex_ov});
            check("rnd uo_out", uo_out, (q.size() > 0) ? q[0] : 8'h00);
            acc_ev = in_valid && ex_ir;
            pop_ev = ex_ov && out_ready;
            if (pop_ev) void'(q.pop_front());
            m_pulse = 1'b0;
            if (acc_ev) begin
                if (load) begin
                    m_acc = ui_in; m_sticky = 1'b0;
                end else begin
                    r = ref_add(m_acc, ui_in, sat);
                    m_acc = r[7:0]; m_pulse = r[8]; m_sticky = m_sticky | r[8];
                end
                q.push_back(m_acc);
            end
            @(posedge clk); #1;
            check("rnd sticky", {7'b0, uio_out[6]}, {7'b0, m_sticky});
            check("rnd pulse", {7'b0, uio_out[7]}, {7'b0, m_pulse});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
